// File: rtl/snax_tcdm_responder_bank_if.sv
// Per-port TCDM request/response bundle between initiators (master) and the responder bank (slave).
// Ports are packed as [NumPorts-1:0][width-1:0].
interface snax_tcdm_responder_bank_if #(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TCDMAddrWidth = 48
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic [NumPorts-1:0]                    req_write;
    logic [NumPorts-1:0][TCDMAddrWidth-1:0] req_addr;
    logic [NumPorts-1:0][DataWidth-1:0]     req_data;
    logic [NumPorts-1:0][StrbWidth-1:0]     req_strb;
    logic [NumPorts-1:0]                    req_q_valid;
    logic [NumPorts-1:0]                    rsp_q_ready;
    logic [NumPorts-1:0]                    rsp_p_valid;
    logic [NumPorts-1:0][DataWidth-1:0]     rsp_data;

    modport master (
        output req_write, req_addr, req_data, req_strb, req_q_valid,
        input  rsp_q_ready, rsp_p_valid, rsp_data
    );

    modport slave (
        input  req_write, req_addr, req_data, req_strb, req_q_valid,
        output rsp_q_ready, rsp_p_valid, rsp_data
    );
endinterface

// File: rtl/snax_tcdm_responder_bank.sv
// Single-ported word memory serving NumPorts TCDM initiators with round-robin arbitration,
// 1-cycle read latency and a saturating bank-conflict cycle counter.
module snax_tcdm_rsp_lane #(
    parameter int unsigned DataWidth = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load,
    input  logic [DataWidth-1:0] din,
    output logic                 p_valid,
    output logic [DataWidth-1:0] data
);
    // Data is only reloaded on a read grant, so it holds the last value read.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_valid <= 1'b0;
            data    <= '0;
        end else begin
            p_valid <= load;
            if (load) data <= din;
        end
    end
endmodule

module snax_tcdm_responder_bank #(
    parameter int unsigned NumPorts      = 4,
    parameter int unsigned DataWidth     = 64,
    parameter int unsigned TCDMAddrWidth = 48,
    parameter int unsigned MemDepth      = 256
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    snax_tcdm_responder_bank_if.slave    tcdm,
    output logic [31:0]                  conflict_cnt_o
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(MemDepth);
    localparam int unsigned PtrWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1;

    typedef struct packed {
        logic                 write;
        logic [IdxWidth-1:0]  idx;
        logic [DataWidth-1:0] data;
        logic [StrbWidth-1:0] strb;
    } gnt_req_t;

    logic [MemDepth-1:0][DataWidth-1:0] mem;
    logic [PtrWidth-1:0]                ptr;
    logic                               gnt_vld;
    logic [PtrWidth-1:0]                gnt_idx;
    gnt_req_t                           gr;
    logic [NumPorts-1:0]                rd_load;
    logic                               multi_req;

    // First valid port at or after the pointer, searching cyclically.
    always_comb begin
        int unsigned p;
        p       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            p = (int'(ptr) + i) % NumPorts;
            if (!gnt_vld && tcdm.req_q_valid[p]) begin
                gnt_vld = 1'b1;
                gnt_idx = PtrWidth'(p);
            end
        end
    end

    always_comb begin
        gr.write = tcdm.req_write[gnt_idx];
        gr.idx   = tcdm.req_addr[gnt_idx][OffWidth +: IdxWidth];
        gr.data  = tcdm.req_data[gnt_idx];
        gr.strb  = tcdm.req_strb[gnt_idx];
    end

    always_comb begin
        tcdm.rsp_q_ready = '0;
        rd_load          = '0;
        if (gnt_vld) begin
            tcdm.rsp_q_ready[gnt_idx] = 1'b1;
            rd_load[gnt_idx]          = !gr.write;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr <= '0;
        end else if (gnt_vld) begin
            ptr <= (gnt_idx == PtrWidth'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Reads sample the array after any prior-cycle write has landed, so no bypass is needed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem <= '0;
        end else if (gnt_vld && gr.write) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (gr.strb[b]) mem[gr.idx][b*8 +: 8] <= gr.data[b*8 +: 8];
            end
        end
    end

    for (genvar g = 0; g < NumPorts; g++) begin : g_lane
        snax_tcdm_rsp_lane #(.DataWidth(DataWidth)) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .load    (rd_load[g]),
            .din     (mem[gr.idx]),
            .p_valid (tcdm.rsp_p_valid[g]),
            .data    (tcdm.rsp_data[g])
        );
    end

    // More than one bit set iff clearing the lowest set bit leaves something.
    assign multi_req = |(tcdm.req_q_valid & (tcdm.req_q_valid - 1'b1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_o <= '0;
        end else if (multi_req && conflict_cnt_o != 32'hFFFF_FFFF) begin
            conflict_cnt_o <= conflict_cnt_o + 32'd1;
        end
    end
endmodule

// File: tb/tb_snax_tcdm_responder_bank.sv
// Directed bench for snax_tcdm_responder_bank: vector table for single-port traffic,
// hand sequences for round-robin contention and reset during a pending read.
module tb_snax_tcdm_responder_bank;
    localparam int NP = 4;
    localparam int DW = 64;
    localparam int AW = 48;
    localparam int MD = 256;

    logic        clk;
    logic        rst_n;
    logic [31:0] conflict_cnt;
    int          n_tests;
    int          n_fail;

    snax_tcdm_responder_bank_if #(.NumPorts(NP), .DataWidth(DW), .TCDMAddrWidth(AW)) bus ();

    snax_tcdm_responder_bank #(
        .NumPorts(NP), .DataWidth(DW), .TCDMAddrWidth(AW), .MemDepth(MD)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .tcdm           (bus),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        int          port;
        logic [47:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        bus.req_q_valid = '0;
        bus.req_write   = '0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.req_strb    = '0;
    endtask

    task automatic drive(input int p, input bit wr, input logic [47:0] a,
                         input logic [63:0] d, input logic [7:0] s);
        bus.req_write[p]   = wr;
        bus.req_addr[p]    = a;
        bus.req_data[p]    = d;
        bus.req_strb[p]    = s;
        bus.req_q_valid[p] = 1'b1;
    endtask

    logic [63:0] exp_rd [NP];
    logic [31:0] cnt0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        clear_reqs();

        vecs[0]  = '{1'b1, 0, 48'h08, 64'h1122_3344_5566_7788, 8'hFF, 64'h0};
        vecs[1]  = '{1'b0, 0, 48'h08, 64'h0, 8'h00, 64'h1122_3344_5566_7788};
        vecs[2]  = '{1'b1, 1, 48'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 64'h0};
        vecs[3]  = '{1'b0, 1, 48'h10, 64'h0, 8'h00, 64'h0000_0000_FFFF_FFFF};
        vecs[4]  = '{1'b0, 2, 48'h808, 64'h0, 8'h00, 64'h1122_3344_5566_7788};
        vecs[5]  = '{1'b1, 3, 48'h18, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 64'h0};
        vecs[6]  = '{1'b0, 3, 48'h18, 64'h0, 8'h00, 64'h0};
        vecs[7]  = '{1'b1, 2, 48'h10, 64'hAABB_CCDD_0000_0000, 8'hF0, 64'h0};
        vecs[8]  = '{1'b0, 0, 48'h10, 64'h0, 8'h00, 64'hAABB_CCDD_FFFF_FFFF};
        vecs[9]  = '{1'b1, 1, 48'hFFFF_0000_0018, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0};
        vecs[10] = '{1'b0, 3, 48'h18, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("reset_q_ready", bus.rsp_q_ready, 0);
        chk("reset_p_valid", bus.rsp_p_valid, 0);
        chk("reset_conflict", conflict_cnt, 0);
        chk("reset_rsp_data0", bus.rsp_data[0], 0);

        // Single-port traffic, issued back to back (write then read of same word in next cycle).
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb);
            #1;
            chk($sformatf("v%0d_q_ready", i), bus.rsp_q_ready, 64'(1) << vecs[i].port);
            @(posedge clk);
            #1;
            clear_reqs();
            chk($sformatf("v%0d_p_valid", i), bus.rsp_p_valid,
                vecs[i].wr ? 64'h0 : (64'(1) << vecs[i].port));
            if (!vecs[i].wr)
                chk($sformatf("v%0d_rsp_data", i), bus.rsp_data[vecs[i].port], vecs[i].exp);
        end
        chk("single_port_no_conflict", conflict_cnt, 0);

        // All four ports read together; pointer is back at 0 after the P3 read above.
        exp_rd[0] = 64'h1122_3344_5566_7788;
        exp_rd[1] = 64'hAABB_CCDD_FFFF_FFFF;
        exp_rd[2] = 64'h0123_4567_89AB_CDEF;
        exp_rd[3] = 64'h0;
        cnt0 = conflict_cnt;
        drive(0, 1'b0, 48'h08, 64'h0, 8'h00);
        drive(1, 1'b0, 48'h10, 64'h0, 8'h00);
        drive(2, 1'b0, 48'h18, 64'h0, 8'h00);
        drive(3, 1'b0, 48'h00, 64'h0, 8'h00);
        for (int k = 0; k < NP; k++) begin
            #1;
            chk($sformatf("rr%0d_q_ready", k), bus.rsp_q_ready, 64'(1) << k);
            @(posedge clk);
            #1;
            bus.req_q_valid[k] = 1'b0;
            chk($sformatf("rr%0d_p_valid", k), bus.rsp_p_valid, 64'(1) << k);
            chk($sformatf("rr%0d_rsp_data", k), bus.rsp_data[k], exp_rd[k]);
        end
        chk("rr_conflict_cnt", conflict_cnt, cnt0 + 32'd3);
        @(posedge clk);
        #1;
        chk("idle_p_valid", bus.rsp_p_valid, 0);
        chk("hold_rsp_data0", bus.rsp_data[0], 64'h1122_3344_5566_7788);
        chk("hold_conflict_cnt", conflict_cnt, cnt0 + 32'd3);

        // Reset right after a read grant: pending response must vanish.
        clear_reqs();
        drive(0, 1'b0, 48'h08, 64'h0, 8'h00);
        @(posedge clk);
        #1;
        clear_reqs();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_p_valid", bus.rsp_p_valid, 0);
        chk("rst_mid_rsp_data", bus.rsp_data[0], 0);
        chk("rst_mid_conflict", conflict_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_no_late_p_valid", bus.rsp_p_valid, 0);

        // P0 and P2 contend; a cleared pointer picks P0 (stale pointer 1 would pick P2).
        drive(0, 1'b0, 48'h08, 64'h0, 8'h00);
        drive(2, 1'b0, 48'h10, 64'h0, 8'h00);
        #1;
        chk("post_rst_grant_p0", bus.rsp_q_ready, 64'h1);
        @(posedge clk);
        #1;
        bus.req_q_valid[0] = 1'b0;
        chk("post_rst_p_valid0", bus.rsp_p_valid, 64'h1);
        chk("post_rst_word1_cleared", bus.rsp_data[0], 0);
        chk("post_rst_grant_p2", bus.rsp_q_ready, 64'h4);
        @(posedge clk);
        #1;
        clear_reqs();
        chk("post_rst_p_valid2", bus.rsp_p_valid, 64'h4);
        chk("post_rst_word2_cleared", bus.rsp_data[2], 0);
        chk("post_rst_conflict", conflict_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
